// File: rtl/bicubic_pad_gen.sv
// bicubic_pad_gen: wraps a raster frame in a 1/2-pixel zero border for the bicubic core.
// Optional BICUBIC_PAD_SIDEBAND_EN adds m_sof/m_eol/m_eof framing outputs.
module bicubic_pad_gen #(
  parameter int SRC_WIDTH = 960,
  parameter int SRC_HEIGHT = 540,
  parameter int PIX_W = 24,
  parameter logic [PIX_W-1:0] PAD_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [PIX_W-1:0] m_data,
  output logic             frame_done
`ifdef BICUBIC_PAD_SIDEBAND_EN
  ,
  output logic             m_sof,
  output logic             m_eol,
  output logic             m_eof
`endif
);
  localparam int CW = $clog2(SRC_WIDTH + 3);
  localparam int RW = $clog2(SRC_HEIGHT + 3);
  logic [CW-1:0] c;
  logic [RW-1:0] r;
  logic is_data, load_en, adv, eol_pos, last_pos, last_q;
  always_comb begin
    is_data = (r >= RW'(1)) && (r <= RW'(SRC_HEIGHT)) && (c >= CW'(1)) && (c <= CW'(SRC_WIDTH));
    load_en = ~m_valid | m_ready;
    s_ready = load_en & is_data;
    adv = load_en & (~is_data | s_valid);
    eol_pos = c == CW'(SRC_WIDTH + 2);
    last_pos = eol_pos && (r == RW'(SRC_HEIGHT + 2));
  end
  // last_q marks that the held beat is the frame's final pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c <= '0;
      r <= '0;
      m_valid <= 1'b0;
      m_data <= '0;
      last_q <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= m_valid & m_ready & last_q;
      if (load_en) begin
        m_valid <= adv;
        m_data <= is_data ? s_data : PAD_VAL;
        last_q <= last_pos;
      end
      if (adv) begin
        c <= eol_pos ? '0 : c + CW'(1);
        if (eol_pos) r <= last_pos ? '0 : r + RW'(1);
      end
    end
  end
`ifdef BICUBIC_PAD_SIDEBAND_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sof <= 1'b0;
      m_eol <= 1'b0;
    end else if (load_en) begin
      m_sof <= (r == '0) && (c == '0);
      m_eol <= eol_pos;
    end
  end
  assign m_eof = last_q;
`endif
endmodule

// File: doc/bicubic_pad_gen.md
Name: bicubic_pad_gen

Overview:
- Sits directly upstream of the bicubic interpolation core and produces the bordered source-frame stream the core consumes.
- Accepts a raw raster-order stream of SRC_WIDTH x SRC_HEIGHT 24-bit RGB pixels and emits (SRC_WIDTH+3) x (SRC_HEIGHT+3) pixels.
- Border layout: one zero row on top, two zero rows on the bottom, one zero column on the left, two zero columns on the right, which is the 4x4-tap window border the core expects.
- Back-to-back frames are supported with no idle cycles required between them.

Parameters:
- SRC_WIDTH, 960: active pixels per source row (codebase supplies `SRC_IMG_WIDTH); must be >= 1.
- SRC_HEIGHT, 540: active rows per source frame (codebase supplies `SRC_IMG_HEIGHT); must be >= 1.
- PIX_W, 24: pixel width, packed {R,G,B}.
- PAD_VAL, 0: value emitted for every border pixel.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous assert, active-high.
- s_valid  in  1  upstream pixel valid.
- s_ready  out  1  upstream ready; a beat transfers when s_valid & s_ready.
- s_data  in  PIX_W  upstream pixel.
- m_valid  out  1  padded pixel valid.
- m_ready  in  1  downstream (bicubic core) ready.
- m_data  out  PIX_W  padded pixel.
- frame_done  out  1  one-cycle pulse when the last padded pixel of a frame is accepted downstream.

Behaviour:
- Reset is asynchronous and active-high. While rst=1: m_valid=0, m_data=0, frame_done=0, s_ready=0, row counter r=0, column counter c=0.
- Counters: r runs 0..SRC_HEIGHT+2 and c runs 0..SRC_WIDTH+2. Together they give the position of the next pixel to be loaded into the output register.
- Position class: DATA when 1<=r<=SRC_HEIGHT and 1<=c<=SRC_WIDTH; otherwise PAD.
- Output register: the single pipeline stage, with no combinational path from s_data to m_data.
  - load_en = ~m_valid | m_ready.
  - PAD position and load_en: m_data<=PAD_VAL, m_valid<=1, advance counters.
  - DATA position and load_en and s_valid: m_data<=s_data, m_valid<=1, advance counters.
  - DATA position and load_en and ~s_valid: m_valid<=0 (bubble), counters hold.
  - ~load_en: m_valid and m_data hold, counters hold.
- s_ready = load_en & DATA position, combinational from the registered state and m_ready. s_ready is never high at a PAD position. Input is stalled during all border emission.
- Counter advance: c<=c+1. When c==SRC_WIDTH+2, set c<=0 and r<=r+1. When additionally r==SRC_HEIGHT+2, set r<=0 (wrap to the next frame).
- Latency: one cycle from an input handshake, or from pad selection, to m_valid/m_data.
- Throughput: one pixel per cycle with continuous s_valid and m_ready.
- After reset release, the first beat (PAD) is presented on m_valid one clock edge later, with no input needed.
- Beats per frame: exactly (SRC_WIDTH+3)*(SRC_HEIGHT+3) m-side and SRC_WIDTH*SRC_HEIGHT s-side.
- frame_done asserts in the cycle after the m-side handshake of the final beat (row SRC_HEIGHT+2, col SRC_WIDTH+2); otherwise 0.
- Simultaneous events: downstream accepting the held beat while the next beat loads in the same cycle is the normal streaming case; data is neither lost nor duplicated.
- Backpressure: m_valid & ~m_ready holds m_data stable and forces s_ready=0.
- Reset mid-frame: all state clears immediately. The partial frame is discarded and the next emission restarts at padded (0,0).
- Upstream must not deliver more than SRC_WIDTH*SRC_HEIGHT beats per frame. Excess beats are simply taken as the next frame's pixels; no error is flagged.

Optional Feature:
- Macro BICUBIC_PAD_SIDEBAND_EN.
- When defined, adds three outputs, each registered alongside m_data and valid only when m_valid=1:
  - m_sof, 1 bit: high on padded (0,0).
  - m_eol, 1 bit: high when c==SRC_WIDTH+2.
  - m_eof, 1 bit: high on the final beat.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- SRC_WIDTH=4, SRC_HEIGHT=3, s_data=1..12 continuous, m_ready=1 -> 42 m-beats.
  - Beats 0..7 are 0; beat 8 is 1; beats 8..11 are 1,2,3,4; beats 12..14 are 0.
  - Rows 4 and 5 are all 0.
  - frame_done pulses once, in the cycle after beat 41's handshake.
- Same stream with s_valid dropped for 3 cycles at pixel 6 -> m_valid has a 3-cycle bubble only at that position; output sequence identical to the first test.
- m_ready toggling 1-0 every cycle -> m_data stable while m_valid&~m_ready; s_ready=0 during those cycles; 42 beats total, all values correct.
- Two back-to-back frames (s_data 1..24) -> 84 beats; second frame begins with 8 zeros, then 13; two frame_done pulses.
- Assert rst at m-beat 20 of a frame, then release -> m_valid=0 immediately; first post-reset beat is padded (0,0)=0; next 12 input pixels are placed from padded (1,1).
- With BICUBIC_PAD_SIDEBAND_EN -> m_sof only on beat 0, m_eol on beats 6,13,...,41, m_eof only on beat 41.
